// File: rtl/decode_stage.sv
// Registered, handshaked instruction decoder: assembles an opcode byte plus optional
// little-endian immediate bytes and presents one decoded instruction per valid/ready transfer.
module decode_stage #(
    parameter int unsigned DATA_W       = 8,
    parameter int unsigned IMM_BYTES    = 1,
    parameter int unsigned HAS_IMM_LDI  = 1,
    parameter int unsigned HAS_IMM_JMP  = 1,
    parameter int unsigned HAS_IMM_CALL = 1
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        flush,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [DATA_W-1:0]           in_byte,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [7:0]                  out_opcode,
    output logic [2:0]                  out_operand1,
    output logic [2:0]                  out_operand2,
    output logic [2:0]                  out_iaddr,
    output logic                        out_iwe,
    output logic [2:0]                  out_oaddr,
    output logic                        out_ore,
    output logic [3:0]                  out_alu_mode,
    output logic                        out_alu_en,
    output logic [IMM_BYTES*DATA_W-1:0] out_imm,
    output logic [2:0]                  out_len,
    output logic                        out_illegal
);

    localparam logic [7:0] OP_MOV  = 8'h01;
    localparam logic [7:0] OP_LDI  = 8'h02;
    localparam logic [7:0] OP_LDX  = 8'h03;
    localparam logic [7:0] OP_STX  = 8'h04;
    localparam logic [7:0] OP_PUSH = 8'h05;
    localparam logic [7:0] OP_POP  = 8'h06;
    localparam logic [7:0] OP_ALU  = 8'h07;
    localparam logic [7:0] OP_CMP  = 8'h08;
    localparam logic [7:0] OP_JMP  = 8'h09;
    localparam logic [7:0] OP_CALL = 8'h0A;

    localparam logic [3:0] ALU_SUB = 4'h1;
    localparam logic [2:0] REG_A   = 3'd0;
    localparam logic [2:0] REG_H   = 3'd6;

    typedef enum logic [1:0] {FETCH, IMM, OUT} state_t;

    state_t     state;
    logic       rdy_q;
    logic [2:0] imm_cnt;

    logic [7:0] op;
    logic [7:0] d_opcode;
    logic [2:0] d_iaddr;
    logic       d_iwe;
    logic [2:0] d_oaddr;
    logic       d_ore;
    logic [3:0] d_alu_mode;
    logic       d_alu_en;
    logic       d_illegal;
    logic       d_needs;
    logic [2:0] d_len;

    assign op       = in_byte[7:0];
    assign in_ready = rdy_q & ~flush;

    always_comb begin
        d_opcode   = op;
        d_iaddr    = '0;
        d_iwe      = 1'b0;
        d_oaddr    = '0;
        d_ore      = 1'b0;
        d_alu_mode = '0;
        d_alu_en   = 1'b0;
        d_illegal  = 1'b0;
        d_needs    = 1'b0;
        casez (op)
            8'b01??????: begin
                d_opcode = OP_MOV;
                d_iaddr  = op[5:3];
                d_iwe    = 1'b1;
                d_oaddr  = op[2:0];
                d_ore    = 1'b1;
            end
            8'b10??????: begin
                d_opcode   = OP_ALU;
                d_iaddr    = REG_A;
                d_iwe      = 1'b1;
                d_alu_mode = {op[3], op[2:0]};
                d_alu_en   = 1'b1;
            end
            8'b11000???: begin
                d_opcode   = OP_CMP;
                d_alu_mode = ALU_SUB;
                d_alu_en   = 1'b1;
            end
            8'b00000???: begin
                d_opcode = OP_LDI;
                d_iaddr  = op[2:0];
                d_iwe    = 1'b1;
                d_needs  = (HAS_IMM_LDI != 0);
            end
            8'b00001???: begin
                d_opcode = OP_LDX;
                d_iaddr  = op[2:0];
                d_iwe    = 1'b1;
            end
            8'b00010???: begin
                d_opcode = OP_POP;
                d_iaddr  = op[2:0];
                d_iwe    = 1'b1;
            end
            8'b00011???: begin
                d_opcode = OP_STX;
                d_oaddr  = op[2:0];
                d_ore    = 1'b1;
            end
            8'b00100???: begin
                d_opcode = OP_PUSH;
                d_oaddr  = op[2:0];
                d_ore    = 1'b1;
            end
            8'b00101000: begin
                d_opcode = OP_JMP;
                d_needs  = (HAS_IMM_JMP != 0);
            end
            8'b00101001: begin
                d_opcode = OP_CALL;
                d_iaddr  = REG_H;
                d_iwe    = 1'b1;
                d_oaddr  = REG_H;
                d_ore    = 1'b1;
                d_needs  = (HAS_IMM_CALL != 0);
            end
            default: d_illegal = 1'b1;
        endcase
        d_len = d_needs ? 3'(IMM_BYTES + 1) : 3'd1;
    end

    // The output registers double as the holding register while immediates arrive.
    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= FETCH;
            rdy_q        <= 1'b1;
            imm_cnt      <= '0;
            out_valid    <= 1'b0;
            out_opcode   <= '0;
            out_operand1 <= '0;
            out_operand2 <= '0;
            out_iaddr    <= '0;
            out_iwe      <= 1'b0;
            out_oaddr    <= '0;
            out_ore      <= 1'b0;
            out_alu_mode <= '0;
            out_alu_en   <= 1'b0;
            out_imm      <= '0;
            out_len      <= '0;
            out_illegal  <= 1'b0;
        end else if (flush) begin
            state     <= FETCH;
            rdy_q     <= 1'b1;
            out_valid <= 1'b0;
        end else begin
            case (state)
                FETCH: begin
                    if (in_valid) begin
                        out_opcode   <= d_opcode;
                        out_operand1 <= op[5:3];
                        out_operand2 <= op[2:0];
                        out_iaddr    <= d_iaddr;
                        out_iwe      <= d_iwe;
                        out_oaddr    <= d_oaddr;
                        out_ore      <= d_ore;
                        out_alu_mode <= d_alu_mode;
                        out_alu_en   <= d_alu_en;
                        out_imm      <= '0;
                        out_len      <= d_len;
                        out_illegal  <= d_illegal;
                        imm_cnt      <= '0;
                        if (d_needs) begin
                            state <= IMM;
                        end else begin
                            state     <= OUT;
                            rdy_q     <= 1'b0;
                            out_valid <= 1'b1;
                        end
                    end
                end
                IMM: begin
                    if (in_valid) begin
                        for (int unsigned k = 0; k < IMM_BYTES; k++) begin
                            if (imm_cnt == 3'(k))
                                out_imm[k*DATA_W +: DATA_W] <= in_byte;
                        end
                        imm_cnt <= imm_cnt + 3'd1;
                        if (imm_cnt == 3'(IMM_BYTES - 1)) begin
                            state     <= OUT;
                            rdy_q     <= 1'b0;
                            out_valid <= 1'b1;
                        end
                    end
                end
                OUT: begin
                    if (out_ready) begin
                        state     <= FETCH;
                        rdy_q     <= 1'b1;
                        out_valid <= 1'b0;
                    end
                end
                default: begin
                    state     <= FETCH;
                    rdy_q     <= 1'b1;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule
